// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns PC_F, drives the IM address, computes the delay-slot next PC
// and fills the IF/ID register. Optional alignment halt is built when FETCH_ALIGN_CHECK_EN is defined.
module if_fetch_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter int          IM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [1:0]  pc_sel,
    input  logic [15:0] imm16_d,
    input  logic [25:0] idx26_d,
    input  logic [31:0] jr_addr,
    input  logic [31:0] instr_f,
    output logic [31:0] im_addr,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc8_d,
    output logic        halted,
    output logic [1:0]  halt_cause,
    output logic [31:0] fetch_cnt
);

    typedef enum logic {
        S_RUN,
        S_HALT
    } state_t;

    localparam logic [1:0] SEL_PC4    = 2'b00;
    localparam logic [1:0] SEL_BRANCH = 2'b01;
    localparam logic [1:0] SEL_JUMP   = 2'b10;

    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_RANGE = 2'b01;
`ifdef FETCH_ALIGN_CHECK_EN
    localparam logic [1:0] CAUSE_ALIGN = 2'b10;
`endif

    // Last fetchable word address; compared against the full 32-bit PC.
    localparam logic [31:0] PC_LAST = PC_RESET + 32'(IM_WORDS) * 32'd4 - 32'd4;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr_d;
    logic [31:0] r_pc_d;
    logic [1:0]  r_halt_cause;
    logic [31:0] r_fetch_cnt;

    state_t      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_instr_d_nxt;
    logic [31:0] w_pc_d_nxt;
    logic [1:0]  w_halt_cause_nxt;
    logic [31:0] w_fetch_cnt_nxt;
    logic [31:0] w_npc;
    logic [31:0] w_branch_tgt;
    logic        w_out_of_range;

    // Redirect targets are relative to pc_d: D holds the branch while F fetches its delay slot.
    assign w_branch_tgt   = r_pc_d + 32'd4 + {{14{imm16_d[15]}}, imm16_d, 2'b00};
    assign w_out_of_range = (r_pc < PC_RESET) || (r_pc > PC_LAST);

    always_comb begin
        case (pc_sel)
            SEL_PC4:    w_npc = r_pc + 32'd4;
            SEL_BRANCH: w_npc = w_branch_tgt;
            SEL_JUMP:   w_npc = {r_pc_d[31:28], idx26_d, 2'b00};
            default:    w_npc = jr_addr;
        endcase
    end

    always_comb begin
        // NOTE: every next-state signal gets a hold value first so no path can infer a latch.
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_instr_d_nxt    = r_instr_d;
        w_pc_d_nxt       = r_pc_d;
        w_halt_cause_nxt = r_halt_cause;
        w_fetch_cnt_nxt  = r_fetch_cnt;

        if (!stall) begin
            case (r_state)
                S_RUN: begin
`ifdef FETCH_ALIGN_CHECK_EN
                    if (r_pc[1:0] != 2'b00) begin
                        w_state_nxt      = S_HALT;
                        w_halt_cause_nxt = CAUSE_ALIGN;
                        w_instr_d_nxt    = 32'd0;
                        w_pc_d_nxt       = r_pc;
                    end else
`endif
                    if (w_out_of_range) begin
                        w_state_nxt      = S_HALT;
                        w_halt_cause_nxt = CAUSE_RANGE;
                        w_instr_d_nxt    = 32'd0;
                        w_pc_d_nxt       = r_pc;
                    end else begin
                        w_pc_nxt        = w_npc;
                        w_instr_d_nxt   = instr_f;
                        w_pc_d_nxt      = r_pc;
                        w_fetch_cnt_nxt = r_fetch_cnt + 32'd1;
                    end
                end
                default: begin
                    // Halted: keep feeding nops downstream, ignore redirects.
                    w_instr_d_nxt = 32'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            r_state      <= S_RUN;
            r_pc         <= PC_RESET;
            r_instr_d    <= 32'd0;
            r_pc_d       <= 32'd0;
            r_halt_cause <= CAUSE_NONE;
            r_fetch_cnt  <= 32'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_instr_d    <= w_instr_d_nxt;
            r_pc_d       <= w_pc_d_nxt;
            r_halt_cause <= w_halt_cause_nxt;
            r_fetch_cnt  <= w_fetch_cnt_nxt;
        end
    end

    assign im_addr    = r_pc;
    assign instr_d    = r_instr_d;
    assign pc_d       = r_pc_d;
    assign pc8_d      = r_pc_d + 32'd8;
    assign halted     = (r_state == S_HALT);
    assign halt_cause = r_halt_cause;
    assign fetch_cnt  = r_fetch_cnt;

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline. Directly upstream of, and feeding, the instruction memory.
- Holds the PC and drives the IM address. Computes the next PC from D-stage branch/jump decisions, with delay-slot semantics.
- Captures the returned instruction into the IF/ID pipeline register. Halts cleanly when fetch leaves the valid IM window.

Parameters:
- PC_RESET, 32'h0000_3000: PC value after reset; also the IM base address.
- IM_WORDS, 4096: IM depth in words. Valid fetch window is [PC_RESET, PC_RESET + 4*IM_WORDS - 4].

Ports:
- clk  in  1  Single clock; all state updates on rising edge.
- reset  in  1  Synchronous, active-high reset.
- stall  in  1  From hazard unit. Holds PC, IF/ID and state.
- pc_sel  in  2  From D-stage control: 00 PC+4, 01 branch taken, 10 j/jal, 11 jr/jalr.
- imm16_d  in  16  D-stage instruction immediate (branch offset).
- idx26_d  in  26  D-stage instruction index (j/jal).
- jr_addr  in  32  Forwarded rs value for jr/jalr.
- instr_f  in  32  Instruction word returned by IM for im_addr (combinational read).
- im_addr  out  32  Current PC (PC_F), driven to IM address.
- instr_d  out  32  IF/ID instruction register.
- pc_d  out  32  IF/ID PC register.
- pc8_d  out  32  pc_d + 8, combinational (link address).
- halted  out  1  High while the FSM is in HALT.
- halt_cause  out  2  00 none, 01 out of range, 10 misaligned.
- fetch_cnt  out  32  Count of instructions accepted into IF/ID.

Behaviour:
- Reset (synchronous, at rising edge with reset=1):
  - pc=PC_RESET; instr_d=0; pc_d=0; state=RUN; halt_cause=0; fetch_cnt=0.
  - Reset has priority over stall and all other inputs, including mid-HALT or mid-stall.
- Branch target: pc_d + 4 + (sign_extend(imm16_d) << 2), 32-bit wrapping add.
- Jump target: {pc_d[31:28], idx26_d, 2'b00}.
- jr target: jr_addr, unmodified.
- Delay slot: D holds the branch while F holds the delay-slot instruction. The delay slot is never flushed. The redirect takes effect on the PC at the next accepted edge.
- FSM state RUN, edge with stall=0, PC in window: pc<=npc; instr_d<=instr_f; pc_d<=pc; fetch_cnt<=fetch_cnt+1 (wraps at 2^32).
- FSM state RUN, edge with stall=0, PC outside window (pc<PC_RESET or pc>last word):
  - state<=HALT; halt_cause<=01; instr_d<=0 (nop); pc_d<=pc.
  - pc and fetch_cnt are unchanged.
- FSM state HALT:
  - pc held.
  - Each edge with stall=0: instr_d<=0.
  - pc_sel is ignored. Exit only via reset.
- stall=1 in any state: pc, instr_d, pc_d, state, fetch_cnt all hold.
- stall with pc_sel!=00 in the same cycle: stall wins and the redirect is dropped. The hazard unit holds D, so pc_sel is re-presented on the next cycle.
- Window check uses a full 32-bit compare; no truncation aliasing.
- im_addr = pc at all times, including HALT.
- halted = (state==HALT).

Optional Feature:
- Macro FETCH_ALIGN_CHECK_EN.
- Defined: in RUN, pc[1:0]!=00 at an accepted edge enters HALT with halt_cause<=10, same actions as out-of-range. Misalignment is checked before range; if both apply, cause is 10.
- Undefined: no alignment check. halt_cause never takes 10; misaligned pc fetches the word at pc & ~3 as IM indexes with pc[13:2].

Test Plan:
- Reset then 3 free-running edges with pc_sel=00 -> im_addr goes 0x3000, 0x3004, 0x3008, 0x300C; fetch_cnt=3; pc_d=0x3008; pc8_d=0x3010.
- Branch: pc_d=0x3010, imm16_d=0xFFFC, pc_sel=01 -> next PC = 0x3004. The delay-slot instruction at 0x3014 is still latched into instr_d.
- j with pc_d=0x3020, idx26_d=0x0000C40 -> next PC = 0x3100. jr with jr_addr=0x3200, pc_sel=11 -> next PC = 0x3200.
- stall=1 for 2 cycles together with pc_sel=01 -> im_addr, instr_d, pc_d and fetch_cnt unchanged; after stall drops, the redirect applies once.
- Sequential fetch reaches pc=0x7000 -> next edge: halted=1, halt_cause=01, instr_d=0, im_addr stays 0x7000. Then pulse reset -> im_addr=0x3000, halted=0, fetch_cnt=0.
- FETCH_ALIGN_CHECK_EN defined, jr_addr=0x3002 -> after redirect: halted=1, halt_cause=10. Same stimulus with the macro undefined -> halted=0, instr_d=IM word 0x3000.
